bus_select_encoder: RTL and testbench



---
 rtl/bus_select_encoder.sv | 95 +++++++++
 tb/tb_bus_select_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_select_encoder.sv
// -----------------------------------------------------------------------------
// bus_select_encoder
//
// Turns the one-hot bus-driver "out" strobes of the datapath into the select
// code for the shared bus multiplexer. The select path is purely combinational
// so the mux settles in the same cycle the control unit raises a strobe.
// A small clocked monitor captures the first driver conflict since reset.
//
// Ports:
//   clock               in   rising-edge clock for the conflict monitor
//   clear               in   asynchronous active-high reset (monitor only)
//   Encoder_signals_in  in   N_IN driver strobes, bit i = source i drives bus
//   Encoder_signals_out out  select code: highest set index, IDLE_CODE if none
//   valid               out  at least one strobe active
//   multi_hot           out  two or more strobes active
//   conflict_sticky     out  set on first edge that sees multi_hot, held
//   conflict_code       out  select code captured at that first conflict
// -----------------------------------------------------------------------------
module bus_select_encoder #(
    parameter int N_IN      = 24,
    parameter int W_OUT     = 5,
    parameter int IDLE_CODE = 31
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_IN-1:0]  Encoder_signals_in,
    output logic [W_OUT-1:0] Encoder_signals_out,
    output logic             valid,
    output logic             multi_hot,
    output logic             conflict_sticky,
    output logic [W_OUT-1:0] conflict_code
);

    logic [W_OUT-1:0] enc_code;
    logic             any_hot;
    logic             many_hot;

    logic             sticky_q, sticky_d;
    logic [W_OUT-1:0] code_q,   code_d;

    // Priority encode: ascending scan, so the last hit (highest index) wins.
    always_comb begin
        enc_code = W_OUT'(IDLE_CODE);
        for (int i = 0; i < N_IN; i++) begin
            if (Encoder_signals_in[i]) begin
                enc_code = W_OUT'(i);
            end
        end
    end

    // Popcount >= 2 without an adder tree: a set bit seen after any earlier
    // set bit means at least two are high. Kept separate from the priority
    // scan so conflict detection does not depend on the winner.
    always_comb begin
        any_hot  = 1'b0;
        many_hot = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (Encoder_signals_in[i]) begin
                if (any_hot) begin
                    many_hot = 1'b1;
                end
                any_hot = 1'b1;
            end
        end
    end

    assign Encoder_signals_out = enc_code;
    assign valid               = any_hot;
    assign multi_hot           = many_hot;

    // Monitor: only the first conflict is recorded; later ones leave the
    // captured code untouched until clear.
    always_comb begin
        sticky_d = sticky_q;
        code_d   = code_q;
        if (many_hot && !sticky_q) begin
            sticky_d = 1'b1;
            code_d   = enc_code;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sticky_q <= 1'b0;
            code_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            code_q   <= code_d;
        end
    end

    assign conflict_sticky = sticky_q;
    assign conflict_code   = code_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// -----------------------------------------------------------------------------
// tb_bus_select_encoder
//
// Self-checking bench for bus_select_encoder. Directed scenarios follow the
// block's intended use; a randomized phase compares against an arithmetic
// reference (highest set bit via log2, conflict via popcount) plus a small
// first-conflict scoreboard.
// -----------------------------------------------------------------------------
module tb_bus_select_encoder;

    localparam int N_IN      = 24;
    localparam int W_OUT     = 5;
    localparam int IDLE_CODE = 31;

    logic             clock;
    logic             clear;
    logic [N_IN-1:0]  Encoder_signals_in;
    logic [W_OUT-1:0] Encoder_signals_out;
    logic             valid;
    logic             multi_hot;
    logic             conflict_sticky;
    logic [W_OUT-1:0] conflict_code;

    int checks = 0;
    int errors = 0;

    // Reference monitor state
    logic       m_sticky;
    int         m_code;

    bus_select_encoder #(
        .N_IN      (N_IN),
        .W_OUT     (W_OUT),
        .IDLE_CODE (IDLE_CODE)
    ) dut (
        .clock               (clock),
        .clear               (clear),
        .Encoder_signals_in  (Encoder_signals_in),
        .Encoder_signals_out (Encoder_signals_out),
        .valid               (valid),
        .multi_hot           (multi_hot),
        .conflict_sticky     (conflict_sticky),
        .conflict_code       (conflict_code)
    );

    // 40 ns period; stimulus changes at posedge+5, checks at posedge+15.
    initial clock = 1'b0;
    always #20 clock = ~clock;

    // Highest set index = floor(log2(v)) = clog2(v+1)-1.
    function automatic int ref_code(logic [N_IN-1:0] v);
        int x;
        x = int'({8'd0, v});
        if (x == 0) return IDLE_CODE;
        return $clog2(x + 1) - 1;
    endfunction

    function automatic logic ref_multi(logic [N_IN-1:0] v);
        return $countones(v) >= 2;
    endfunction

    task automatic test_reset();
        clear = 1'b1;
        Encoder_signals_in = '0;
        #7;
        checks++;
        if (conflict_sticky !== 1'b0 || conflict_code !== '0) begin
            errors++;
            $display("FAIL reset_during got sticky=%b code=%0d exp 0/0", conflict_sticky, conflict_code);
        end
        @(posedge clock); #5;
        clear = 1'b0;
        #10;
        checks++;
        if (Encoder_signals_out !== 5'd31 || valid !== 1'b0 || multi_hot !== 1'b0) begin
            errors++;
            $display("FAIL idle got out=%0d valid=%b multi=%b exp 31/0/0", Encoder_signals_out, valid, multi_hot);
        end
        @(posedge clock); #1;
        checks++;
        if (conflict_sticky !== 1'b0 || conflict_code !== '0) begin
            errors++;
            $display("FAIL reset_after got sticky=%b code=%0d exp 0/0", conflict_sticky, conflict_code);
        end
    endtask

    task automatic test_single();
        logic [N_IN-1:0] pats [4];
        int              exps [4];
        pats[0] = 24'h000002; exps[0] = 1;
        pats[1] = 24'h001000; exps[1] = 12;
        pats[2] = 24'h800000; exps[2] = 23;
        pats[3] = 24'h000001; exps[3] = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #5;
            Encoder_signals_in = pats[k];
            #10;
            checks++;
            if (Encoder_signals_out !== W_OUT'(exps[k]) || valid !== 1'b1 || multi_hot !== 1'b0) begin
                errors++;
                $display("FAIL single in=%h got out=%0d valid=%b multi=%b exp %0d/1/0",
                         pats[k], Encoder_signals_out, valid, multi_hot, exps[k]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int b = 0; b < N_IN; b++) begin
            @(posedge clock); #5;
            Encoder_signals_in = '0;
            Encoder_signals_in[b] = 1'b1;
            #10;
            checks++;
            if (Encoder_signals_out !== W_OUT'(b) || conflict_sticky !== 1'b0) begin
                errors++;
                $display("FAIL sweep bit=%0d got out=%0d sticky=%b exp %0d/0",
                         b, Encoder_signals_out, conflict_sticky, b);
            end
        end
        @(posedge clock); #1;
        checks++;
        if (conflict_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sweep_sticky got %b exp 0", conflict_sticky);
        end
    endtask

    task automatic test_priority();
        @(posedge clock); #5;
        Encoder_signals_in = 24'h010010;
        #10;
        checks++;
        if (Encoder_signals_out !== 5'd16 || multi_hot !== 1'b1 || valid !== 1'b1 || conflict_sticky !== 1'b0) begin
            errors++;
            $display("FAIL prio_comb got out=%0d multi=%b valid=%b sticky=%b exp 16/1/1/0",
                     Encoder_signals_out, multi_hot, valid, conflict_sticky);
        end
        @(posedge clock); #1;
        checks++;
        if (conflict_sticky !== 1'b1 || conflict_code !== 5'd16) begin
            errors++;
            $display("FAIL prio_capture got sticky=%b code=%0d exp 1/16", conflict_sticky, conflict_code);
        end
    endtask

    task automatic test_sticky_hold();
        #4;
        Encoder_signals_in = 24'h000005;
        #10;
        checks++;
        if (Encoder_signals_out !== 5'd2 || multi_hot !== 1'b1) begin
            errors++;
            $display("FAIL hold_comb got out=%0d multi=%b exp 2/1", Encoder_signals_out, multi_hot);
        end
        @(posedge clock); #5;
        checks++;
        if (conflict_sticky !== 1'b1 || conflict_code !== 5'd16) begin
            errors++;
            $display("FAIL hold_code got sticky=%b code=%0d exp 1/16", conflict_sticky, conflict_code);
        end
        Encoder_signals_in = 24'h000100;
        @(posedge clock); #1;
        checks++;
        if (conflict_sticky !== 1'b1 || conflict_code !== 5'd16 || Encoder_signals_out !== 5'd8) begin
            errors++;
            $display("FAIL hold_single got sticky=%b code=%0d out=%0d exp 1/16/8",
                     conflict_sticky, conflict_code, Encoder_signals_out);
        end
    endtask

    task automatic test_async_clear();
        // Sticky is 1 here; clear mid-cycle must drop it with no edge.
        #9;
        Encoder_signals_in = 24'h400003;
        clear = 1'b1;
        #2;
        checks++;
        if (conflict_sticky !== 1'b0 || conflict_code !== '0) begin
            errors++;
            $display("FAIL async_clear got sticky=%b code=%0d exp 0/0", conflict_sticky, conflict_code);
        end
        checks++;
        if (Encoder_signals_out !== 5'd22 || multi_hot !== 1'b1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL comb_in_reset got out=%0d multi=%b valid=%b exp 22/1/1",
                     Encoder_signals_out, multi_hot, valid);
        end
        // Conflict held across an edge while clear is high.
        @(posedge clock); #1;
        checks++;
        if (conflict_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clear_dominates got sticky=%b exp 0", conflict_sticky);
        end
        #4;
        clear = 1'b0;
        #10;
        checks++;
        if (conflict_sticky !== 1'b0) begin
            errors++;
            $display("FAIL release_no_edge got sticky=%b exp 0", conflict_sticky);
        end
        @(posedge clock); #1;
        checks++;
        if (conflict_sticky !== 1'b1 || conflict_code !== 5'd22) begin
            errors++;
            $display("FAIL release_capture got sticky=%b code=%0d exp 1/22", conflict_sticky, conflict_code);
        end
    endtask

    task automatic test_random();
        logic [N_IN-1:0] v;
        int              kind;
        // Start from a clean monitor.
        #4;
        clear = 1'b1;
        Encoder_signals_in = '0;
        #2;
        clear = 1'b0;
        m_sticky = 1'b0;
        m_code   = 0;
        for (int it = 0; it < 300; it++) begin
            @(posedge clock);
            // Scoreboard sees the value that was present at this edge.
            if (ref_multi(Encoder_signals_in) && !m_sticky) begin
                m_sticky = 1'b1;
                m_code   = ref_code(Encoder_signals_in);
            end
            #5;
            if ($urandom_range(0, 15) == 0) begin
                clear = 1'b1;
                #1;
                clear = 1'b0;
                m_sticky = 1'b0;
                m_code   = 0;
            end
            kind = $urandom_range(0, 5);
            case (kind)
                0:       v = '0;
                1, 2:    begin v = '0; v[$urandom_range(0, N_IN-1)] = 1'b1; end
                3:       begin v = '0; v[$urandom_range(0, N_IN-1)] = 1'b1;
                               v[$urandom_range(0, N_IN-1)] = 1'b1; end
                default: v = N_IN'($urandom);
            endcase
            Encoder_signals_in = v;
            #10;
            checks++;
            if (Encoder_signals_out !== W_OUT'(ref_code(v)) || valid !== (v != 0) ||
                multi_hot !== ref_multi(v)) begin
                errors++;
                $display("FAIL rand_comb in=%h got out=%0d valid=%b multi=%b exp %0d/%b/%b",
                         v, Encoder_signals_out, valid, multi_hot, ref_code(v), v != 0, ref_multi(v));
            end
            checks++;
            if (conflict_sticky !== m_sticky || conflict_code !== W_OUT'(m_code)) begin
                errors++;
                $display("FAIL rand_mon it=%0d got sticky=%b code=%0d exp %b/%0d",
                         it, conflict_sticky, conflict_code, m_sticky, m_code);
            end
        end
    endtask

    initial begin
        clear = 1'b0;
        Encoder_signals_in = '0;
        m_sticky = 1'b0;
        m_code   = 0;
        test_reset();
        test_single();
        test_sweep();
        test_priority();
        test_sticky_hold();
        test_async_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
